// File: rtl/jk_bank_driver.sv
// jk_bank_driver: turns "write this word" requests into one-edge J/K command cycles on a JK bank.
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   tgt_valid/tgt_ready  request handshake; ready only while idle
//   tgt_data, tgt_mode   requested bank value; 0 = set/reset, 1 = toggle excitation
//   q_in                 live q of the driven bank
//   j, k                 registered excitation, nonzero only for the single drive cycle
//   done, err, mismatch  completion pulse, readback error flag, per-bit q_in ^ target
// Option: define JKDRV_RETRY_EN to retry a mismatching request once before reporting.
module jk_bank_driver #(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tgt_valid,
   output logic             tgt_ready,
   input  logic [WIDTH-1:0] tgt_data,
   input  logic             tgt_mode,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] mismatch
);
   localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
   typedef enum logic [1:0] {IDLE, DRIVE, WAIT, RETRY} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] tgt_q, src, dif, j_nx, k_nx, mis_nx;
   logic mode_q, md, fire, cmp, load, redo;
`ifdef JKDRV_RETRY_EN
   logic retried;
`endif
   always_comb begin
      fire = tgt_valid && state == IDLE;
      cmp = state == WAIT && cnt == '0;
      // excitation source: live request on accept, captured target on retry
      src = fire ? tgt_data : tgt_q;
      md = fire ? tgt_mode : mode_q;
      dif = src ^ q_in;
      j_nx = md ? dif : src & ~q_in;
      k_nx = md ? dif : ~src & q_in;
      mis_nx = q_in ^ tgt_q;
`ifdef JKDRV_RETRY_EN
      redo = cmp && |mis_nx && !retried;
`else
      redo = 1'b0;
`endif
      load = fire || state == RETRY;
      tgt_ready = state == IDLE;
      state_nx = fire ? DRIVE : state == DRIVE ? WAIT : state == RETRY ? DRIVE :
                 cmp ? (redo ? RETRY : IDLE) : state;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         tgt_q <= '0;
         mode_q <= 1'b0;
         j <= '0;
         k <= '0;
         done <= 1'b0;
         err <= 1'b0;
         mismatch <= '0;
      end else begin
         state <= state_nx;
         j <= load ? j_nx : '0;
         k <= load ? k_nx : '0;
         done <= cmp && !redo;
         cnt <= state == DRIVE ? CW'(SETTLE - 1) : cmp ? cnt : state == WAIT ? cnt - CW'(1) : cnt;
         if (fire) begin
            tgt_q <= tgt_data;
            mode_q <= tgt_mode;
         end
         if (cmp && !redo) begin
            err <= |mis_nx;
            mismatch <= mis_nx;
         end
      end
   end
`ifdef JKDRV_RETRY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) retried <= 1'b0;
      else if (fire) retried <= 1'b0;
      else if (redo) retried <= 1'b1;
   end
`endif
endmodule

// File: tb/tb_jk_bank_driver.sv
// tb_jk_bank_driver: randomized self-checking bench with a JK bank model on j/k.
module tb_jk_bank_driver;
   logic clk, rst_n, tgt_valid, tgt_ready, tgt_mode, done, err, ld;
   logic [7:0] tgt_data, q_in, j, k, mismatch, bank, frc, ld_val;
   int checks = 0, errors = 0;

   jk_bank_driver #(.WIDTH(8), .SETTLE(2)) dut (
      .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
      .tgt_data(tgt_data), .tgt_mode(tgt_mode), .q_in(q_in), .j(j), .k(k),
      .done(done), .err(err), .mismatch(mismatch));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // JK bank: Q+ = J~Q + ~KQ; an external agent may pull bits low via frc
   always @(posedge clk) bank <= ld ? ld_val : (j & ~bank) | (~k & bank);
   assign q_in = bank & ~frc;

   function automatic logic [7:0] exp_j(input logic [7:0] t, input logic [7:0] q, input logic m);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = m ? (t[i] != q[i]) : (t[i] && !q[i]);
      return r;
   endfunction

   function automatic logic [7:0] exp_k(input logic [7:0] t, input logic [7:0] q, input logic m);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = m ? (t[i] != q[i]) : (!t[i] && q[i]);
      return r;
   endfunction

   task automatic load_bank(input logic [7:0] v);
      @(negedge clk);
      ld = 1'b1;
      ld_val = v;
      @(posedge clk);
      #1 ld = 1'b0;
   endtask

   task automatic run_req(input logic [7:0] t, input logic m, input logic [7:0] fm,
                          output logic [7:0] jo, output logic [7:0] ko, output logic [7:0] wjk,
                          output int lat, output logic eo, output logic [7:0] mo,
                          output logic [7:0] qo, output logic rb);
      @(negedge clk);
      tgt_valid = 1'b1;
      tgt_data = t;
      tgt_mode = m;
      @(posedge clk);
      #1;
      tgt_valid = 1'b0;
      tgt_data = 8'($urandom);
      jo = j;
      ko = k;
      rb = tgt_ready;
      wjk = '0;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (n == 1) frc = fm;
         if (done) begin
            lat = n;
            break;
         end
         wjk |= j | k;
         rb |= tgt_ready;
      end
      eo = err;
      mo = mismatch;
      qo = q_in;
      frc = '0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tgt_valid = 1'b1;
      tgt_data = 8'hFF;
      tgt_mode = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (j !== 8'h00 || k !== 8'h00) begin errors++; $display("FAIL reset_jk: got j=%h k=%h expected 00 00", j, k); end
      checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err: got %b %b expected 0 0", done, err); end
      checks++; if (mismatch !== 8'h00) begin errors++; $display("FAIL reset_mismatch: got %h expected 00", mismatch); end
      checks++; if (tgt_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", tgt_ready); end
      @(negedge clk);
      tgt_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (tgt_ready !== 1'b1 || j !== 8'h00) begin errors++; $display("FAIL reset_release: got ready=%b j=%h expected 1 00", tgt_ready, j); end
   endtask

   task automatic test_reset_mid_drive;
      bit seen = 0;
      load_bank(8'h0F);
      @(negedge clk);
      tgt_valid = 1'b1;
      tgt_data = 8'hA5;
      tgt_mode = 1'b0;
      @(posedge clk);
      #1 tgt_valid = 1'b0;
      checks++; if (j !== 8'hA0) begin errors++; $display("FAIL mid_drive_j: got %h expected a0", j); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (j !== 8'h00 || k !== 8'h00) begin errors++; $display("FAIL mid_drive_reset_jk: got j=%h k=%h expected 00 00", j, k); end
      @(posedge clk);
      #1;
      checks++; if (bank !== 8'h0F) begin errors++; $display("FAIL mid_drive_bank: got %h expected 0f", bank); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 6; n++) begin
         @(posedge clk);
         #1 if (done) seen = 1;
      end
      checks++; if (seen) begin errors++; $display("FAIL mid_drive_no_done: got done pulse expected none"); end
      checks++; if (tgt_ready !== 1'b1 || q_in !== 8'h0F) begin errors++; $display("FAIL mid_drive_after: got ready=%b bank=%h expected 1 0f", tgt_ready, q_in); end
   endtask

   task automatic test_mode0;
      logic [7:0] jo, ko, wjk, mo, qo;
      logic eo, rb;
      int lat;
      load_bank(8'h0F);
      run_req(8'hA5, 1'b0, 8'h00, jo, ko, wjk, lat, eo, mo, qo, rb);
      checks++; if (jo !== 8'hA0 || ko !== 8'h0A) begin errors++; $display("FAIL mode0_jk: got j=%h k=%h expected a0 0a", jo, ko); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL mode0_latency: got %0d expected 3", lat); end
      checks++; if (qo !== 8'hA5 || eo !== 1'b0 || mo !== 8'h00) begin errors++; $display("FAIL mode0_result: got bank=%h err=%b mis=%h expected a5 0 00", qo, eo, mo); end
      checks++; if (wjk !== 8'h00 || rb !== 1'b0) begin errors++; $display("FAIL mode0_wait: got jk=%h ready=%b expected 00 0", wjk, rb); end
   endtask

   task automatic test_mode1;
      logic [7:0] jo, ko, wjk, mo, qo;
      logic eo, rb;
      int lat;
      load_bank(8'h3C);
      run_req(8'hC3, 1'b1, 8'h00, jo, ko, wjk, lat, eo, mo, qo, rb);
      checks++; if (jo !== 8'hFF || ko !== 8'hFF || wjk !== 8'h00) begin errors++; $display("FAIL mode1_jk: got j=%h k=%h wait=%h expected ff ff 00", jo, ko, wjk); end
      checks++; if (qo !== 8'hC3 || eo !== 1'b0 || lat !== 3) begin errors++; $display("FAIL mode1_result: got bank=%h err=%b lat=%0d expected c3 0 3", qo, eo, lat); end
   endtask

   task automatic test_noop;
      logic [7:0] jo, ko, wjk, mo, qo;
      logic eo, rb;
      int lat;
      load_bank(8'h55);
      run_req(8'h55, 1'b0, 8'h00, jo, ko, wjk, lat, eo, mo, qo, rb);
      checks++; if ((jo | ko | wjk) !== 8'h00) begin errors++; $display("FAIL noop_jk: got j=%h k=%h wait=%h expected 00", jo, ko, wjk); end
      checks++; if (lat !== 3 || eo !== 1'b0 || qo !== 8'h55) begin errors++; $display("FAIL noop_result: got lat=%0d err=%b bank=%h expected 3 0 55", lat, eo, qo); end
   endtask

   task automatic test_disturbed;
      logic [7:0] jo, ko, wjk, mo, qo, t, fm, em;
      logic eo, rb;
      int lat;
      t = 8'hFF;
      fm = 8'h04;
      em = (t & ~fm) ^ t;
      load_bank(8'h00);
      run_req(t, 1'b0, fm, jo, ko, wjk, lat, eo, mo, qo, rb);
      checks++; if (lat !== 3) begin errors++; $display("FAIL disturbed_latency: got %0d expected 3", lat); end
      checks++; if (eo !== |em || mo !== em) begin errors++; $display("FAIL disturbed_result: got err=%b mis=%h expected %b %h", eo, mo, |em, em); end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (err !== 1'b1 || mismatch !== em || done !== 1'b0) begin errors++; $display("FAIL disturbed_hold: got err=%b mis=%h done=%b expected 1 %h 0", err, mismatch, done, em); end
      run_req(8'h0F, 1'b1, 8'h00, jo, ko, wjk, lat, eo, mo, qo, rb);
      checks++; if (eo !== 1'b0 || mo !== 8'h00 || qo !== 8'h0F) begin errors++; $display("FAIL disturbed_clear: got err=%b mis=%h bank=%h expected 0 00 0f", eo, mo, qo); end
   endtask

   task automatic test_random;
      logic [7:0] jo, ko, wjk, mo, qo, b, t;
      logic eo, rb, m;
      int lat;
      for (int i = 0; i < 16; i++) begin
         b = 8'($urandom);
         t = 8'($urandom);
         m = 1'($urandom_range(0, 1));
         load_bank(b);
         run_req(t, m, 8'h00, jo, ko, wjk, lat, eo, mo, qo, rb);
         checks++; if (jo !== exp_j(t, b, m) || ko !== exp_k(t, b, m)) begin errors++; $display("FAIL rand_jk[%0d]: got j=%h k=%h expected %h %h", i, jo, ko, exp_j(t, b, m), exp_k(t, b, m)); end
         checks++; if (lat !== 3 || eo !== 1'b0 || mo !== 8'h00 || qo !== t || wjk !== 8'h00) begin errors++; $display("FAIL rand_result[%0d]: got lat=%0d err=%b mis=%h bank=%h wait=%h expected 3 0 00 %h 00", i, lat, eo, mo, qo, wjk, t); end
      end
   endtask

   task automatic test_back_to_back;
      int d[$];
      logic rdy_at_done = 1'b0;
      load_bank(8'h00);
      @(negedge clk);
      tgt_valid = 1'b1;
      tgt_data = 8'h01;
      tgt_mode = 1'b0;
      for (int n = 0; n < 12; n++) begin
         @(posedge clk);
         #1;
         if (n == 0) tgt_data = 8'h80;
         if (n == 4) begin
            tgt_valid = 1'b0;
            checks++; if (j !== 8'h80 || k !== 8'h01) begin errors++; $display("FAIL b2b_second_accept: got j=%h k=%h expected 80 01", j, k); end
         end
         if (done) begin
            d.push_back(n);
            if (d.size() == 1) rdy_at_done = tgt_ready;
         end
      end
      checks++; if (d.size() !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", d.size()); end
      else begin
         checks++; if (d[0] !== 3 || d[1] - d[0] !== 4) begin errors++; $display("FAIL b2b_spacing: got first=%0d gap=%0d expected 3 4", d[0], d[1] - d[0]); end
      end
      checks++; if (rdy_at_done !== 1'b1 || q_in !== 8'h80) begin errors++; $display("FAIL b2b_final: got ready=%b bank=%h expected 1 80", rdy_at_done, q_in); end
   endtask

   initial begin
      ld = 1'b0;
      ld_val = '0;
      frc = '0;
      test_reset;
      test_reset_mid_drive;
      test_mode0;
      test_mode1;
      test_noop;
      test_disturbed;
      test_random;
      test_back_to_back;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/jk_bank_driver.md
# jk_bank_driver

Command-side driver for a bank of `WIDTH` JK flip-flops. It accepts a target word through a valid/ready handshake and computes per-bit J/K excitation from the bank's current `q`. It drives that excitation for exactly one clock edge, waits a settle interval, then reads the bank back and reports done and any mismatch. It sits between control logic and any JK register bank, so software-style "write value" requests become JK command cycles.

## Interface
- `WIDTH`, 8: number of JK flip-flops driven; must be ≥1.
- `SETTLE`, 2: cycles between the excitation edge and the readback compare; must be ≥1 (0 is illegal).

- `clk`  in  1  rising-edge clock shared with the driven JK bank.
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low.
- `tgt_valid`  in  1  target request valid.
- `tgt_ready`  out  1  driver can accept; high only in IDLE.
- `tgt_data`  in  WIDTH  requested bank value.
- `tgt_mode`  in  1  0 = set/reset excitation, 1 = toggle excitation.
- `q_in`  in  WIDTH  current `q` of the driven bank.
- `j`  out  WIDTH  J inputs to bank, registered.
- `k`  out  WIDTH  K inputs to bank, registered.
- `done`  out  1  one-cycle pulse when a request completes.
- `err`  out  1  valid with `done`: readback ≠ target.
- `mismatch`  out  WIDTH  valid with `done`: `q_in` XOR target at compare.

## Operation
- States:
  - IDLE: `tgt_ready`=1; `tgt_valid`&`tgt_ready` at an edge → DRIVE.
  - DRIVE: exactly one cycle → WAIT.
  - WAIT: `SETTLE` cycles, counter counts down → back to IDLE with compare.
- Accept edge:
  - Capture `tgt_data` and `tgt_mode` into `tgt_q`.
  - Register excitation computed per bit from `q_in` sampled at that edge.
- Mode 0 excitation:
  - target 1, q 0 → J=1, K=0.
  - target 0, q 1 → J=0, K=1.
  - bits already equal → J=K=0 (hold).
- Mode 1 excitation: differing bits → J=K=1 (toggle); equal bits → J=K=0.
- `j`/`k` are nonzero only during the DRIVE cycle. They return to all-zero (hold) at the DRIVE→WAIT edge.
- Compare at the final WAIT edge:
  - `mismatch` ← `q_in` ^ `tgt_q`.
  - `err` ← |mismatch.
  - `done` ← 1.
  - State → IDLE.
- A target equal to `q_in` still runs the full sequence with all-zero excitation; the expected result is `err`=0.
- `err` and `mismatch` hold their values until the next `done`. `done` is a single-cycle pulse.
- `tgt_valid` and `tgt_data` outside IDLE are ignored. There is no queuing.

## Timing
- Accept edge E0 → `j`/`k` valid during E0..E1 → bank samples at E1.
- Compare edge is E1+`SETTLE`. `done` is high for the cycle after it. Accept-to-done latency is `SETTLE`+1 edges.
- `tgt_ready` is low from E0 and returns high in the same cycle `done` is high. A new request may be accepted on that cycle's ending edge.
- Back-to-back throughput: one request every `SETTLE`+2 cycles.
- Reset values (immediate on `rst_n` low, any state, including mid-DRIVE):
  - `j`=0, `k`=0.
  - `done`=0, `err`=0, `mismatch`=0.
  - state IDLE, `tgt_ready`=1.
  - No request is accepted while `rst_n` is low.
- A request aborted by reset produces no `done`.
- The compare uses `q_in` combinationally at the compare edge. Bank `q` changes due to other agents during WAIT are reported as mismatches.

## Configuration
- `JKDRV_RETRY_EN` defined:
  - A mismatching compare does not raise `done`. It re-enters DRIVE once, recomputing excitation for `tgt_q` from the current `q_in` in the original mode, then WAIT again.
  - `done` and `err` are reported after the second compare.
  - Failing latency is 2×(`SETTLE`+1)+1 edges; passing latency is unchanged.
- `JKDRV_RETRY_EN` not defined: a single attempt; the first compare result is reported directly.

## Test plan
The bench models an 8-bit JK bank on `j`/`k`; `WIDTH`=8, `SETTLE`=2.

- Reset mid-DRIVE:
  - Stimulus: `rst_n` low during the DRIVE cycle.
  - Required: `j`=`k`=0 at once; no `done`; `tgt_ready`=1 after release; bank unchanged from its pre-edge value.
- Mode 0 set/reset:
  - Stimulus: bank=0x0F, target 0xA5.
  - Required during DRIVE: `j`=0xA0, `k`=0x0A.
  - Required at `done` (3 edges after accept): bank=0xA5, `err`=0, `mismatch`=0x00.
- Mode 1 toggle:
  - Stimulus: bank=0x3C, target 0xC3.
  - Required: `j`=`k`=0xFF for one cycle; bank=0xC3; `err`=0.
- No-op request:
  - Stimulus: bank=0x55, target 0x55 mode 0.
  - Required: `j`=`k`=0x00 throughout; `done` after 3 edges; `err`=0.
- Disturbed bank:
  - Stimulus: the model forces bit 2 low during WAIT, target 0xFF.
  - Required: `err`=1, `mismatch`=0x04.
  - With `JKDRV_RETRY_EN` defined: a second DRIVE with `j`=0x04; `done` follows with `err`=0 if the force is released.
- Back-to-back:
  - Stimulus: `tgt_valid` held high with targets 0x01 then 0x80.
  - Required: the second accept occurs in the first target's `done` cycle; two `done` pulses 4 cycles apart.
